// File: rtl/timer_ctrl.sv
// timer_ctrl: run controller for the four-digit MM:SS timer.
// Paces the seconds-units digit with one-cycle increase/decrease strobes,
// broadcasts the controller state to the digit chain and stops at the
// terminal count (59:59 counting up, 00:00 counting down).
module timer_ctrl #(
   parameter int TICK_DIV = 100,
   parameter int TICK_W   = 7
) (
   input  logic       clk_out,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       up_dn,
   input  logic [3:0] sec0,
   input  logic [3:0] sec1,
   input  logic [3:0] min0,
   input  logic [3:0] min1,
   output logic       increase,
   output logic       decrease,
   output logic [2:0] state,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_RUN   = 3'b001,
      S_PAUSE = 3'b010,
      S_DONE  = 3'b011,
      S_CLEAR = 3'b100
   } state_t;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   state_t            r_state;
   logic              r_dir;
   logic [TICK_W-1:0] r_tick_cnt;
   logic              r_increase;
   logic              r_decrease;
   logic              r_done;

   logic w_full_up;
   logic w_all_zero;
   logic w_term_run;
   logic w_term_start;
   logic w_tick_wrap;

   // Digit comparisons for both terminal values.
   assign w_full_up  = (min1 == 4'd5) && (min0 == 4'd9) &&
                       (sec1 == 4'd5) && (sec0 == 4'd9);
   assign w_all_zero = (min1 == 4'd0) && (min0 == 4'd0) &&
                       (sec1 == 4'd0) && (sec0 == 4'd0);

   // While running the latched direction decides; at start the live up_dn does.
   assign w_term_run   = r_dir ? w_full_up : w_all_zero;
   assign w_term_start = up_dn ? w_full_up : w_all_zero;
   assign w_tick_wrap  = (r_tick_cnt == TICK_LAST);

   // Controller state, tick pacing and registered strobes/done.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_dir      <= 1'b1;
         r_tick_cnt <= '0;
         r_increase <= 1'b0;
         r_decrease <= 1'b0;
         r_done     <= 1'b0;
      end else if (clear) begin
         // Clear beats every other event, including a coincident start_stop.
         r_state    <= S_CLEAR;
         r_tick_cnt <= '0;
         r_increase <= 1'b0;
         r_decrease <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         // Strobes are single-cycle: default low, raised only on a tick wrap.
         r_increase <= 1'b0;
         r_decrease <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start_stop && !w_term_start) begin
                  r_dir      <= up_dn;
                  r_tick_cnt <= '0;
                  r_state    <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (w_term_run) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (start_stop) begin
                  // Tick count is held so resume stays tick-exact.
                  r_state <= S_PAUSE;
                  r_done  <= 1'b0;
               end else begin
                  r_state <= S_RUN;
                  r_done  <= 1'b0;
                  if (w_tick_wrap) begin
                     r_tick_cnt <= '0;
                     r_increase <= r_dir;
                     r_decrease <= ~r_dir;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               r_done <= 1'b0;
               if (start_stop) begin
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_PAUSE;
               end
            end
            S_DONE: begin
               // Only clear leaves DONE; start_stop is ignored here.
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
            S_CLEAR: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign state    = r_state;
   assign increase = r_increase;
   assign decrease = r_decrease;
   assign done     = r_done;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl with TICK_DIV=4.
// The digit chain is represented as a single seconds total (0..3599) that
// follows the expected strobes and is presented to the DUT as BCD digits.
module tb_timer_ctrl;

   localparam int TD = 4;
   localparam logic [2:0] S_IDLE  = 3'b000;
   localparam logic [2:0] S_RUN   = 3'b001;
   localparam logic [2:0] S_PAUSE = 3'b010;
   localparam logic [2:0] S_DONE  = 3'b011;
   localparam logic [2:0] S_CLEAR = 3'b100;

   logic       clk_out = 1'b0;
   logic       reset = 1'b1;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       up_dn = 1'b1;
   logic [3:0] sec0 = 4'd0, sec1 = 4'd0, min0 = 4'd0, min1 = 4'd0;
   logic       increase, decrease, done;
   logic [2:0] state;

   timer_ctrl #(.TICK_DIV(TD), .TICK_W(7)) dut (
      .clk_out(clk_out), .reset(reset), .start_stop(start_stop),
      .clear(clear), .up_dn(up_dn),
      .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
      .increase(increase), .decrease(decrease), .state(state), .done(done)
   );

   always #5 clk_out = ~clk_out;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: seconds total plus expected controller outputs.
   int         total   = 0;
   logic [2:0] m_state = S_IDLE;
   logic       m_up    = 1'b1;
   int         m_run   = 0;     // RUN cycles elapsed since the last strobe/start
   logic       m_inc   = 1'b0;
   logic       m_dec   = 1'b0;
   logic       m_done  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_digits();
      int mm, ss;
      mm = total / 60;
      ss = total % 60;
      min1 = 4'(mm / 10);
      min0 = 4'(mm % 10);
      sec1 = 4'(ss / 10);
      sec0 = 4'(ss % 10);
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_up = 1'b1; m_run = 0;
      m_inc = 1'b0; m_dec = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_step();
      logic p_inc, p_dec, p_clr;
      bit   term_run, term_start;
      p_inc = m_inc;
      p_dec = m_dec;
      p_clr = (m_state == S_CLEAR);
      if (reset) begin
         model_reset();
      end else begin
         term_run   = m_up  ? (total == 3599) : (total == 0);
         term_start = up_dn ? (total == 3599) : (total == 0);
         m_inc = 1'b0;
         m_dec = 1'b0;
         if (clear) begin
            m_state = S_CLEAR;
            m_run   = 0;
         end else begin
            case (m_state)
               S_IDLE:  if (start_stop && !term_start) begin
                           m_up = up_dn; m_run = 0; m_state = S_RUN;
                        end
               S_RUN:   if (term_run) m_state = S_DONE;
                        else if (start_stop) m_state = S_PAUSE;
                        else begin
                           m_run++;
                           if (m_run == TD) begin
                              m_run = 0;
                              if (m_up) m_inc = 1'b1; else m_dec = 1'b1;
                           end
                        end
               S_PAUSE: if (start_stop) m_state = S_RUN;
               S_CLEAR: m_state = S_IDLE;
               default: ;
            endcase
         end
      end
      m_done = (m_state == S_DONE);
      // Digit chain registers the strobe/clear seen during the previous cycle.
      if (p_clr)      total = 0;
      else if (p_inc) total = (total + 1) % 3600;
      else if (p_dec) total = (total + 3599) % 3600;
   endtask

   initial forever begin
      @(posedge clk_out);
      model_step();
   end

   // Every cycle: compare all outputs, then present the updated digits.
   initial forever begin
      @(negedge clk_out);
      chk("state",    state,    m_state);
      chk("increase", increase, m_inc);
      chk("decrease", decrease, m_dec);
      chk("done",     done,     m_done);
      drive_digits();
   end

   task automatic pulse_ss();
      start_stop = 1'b1;
      @(negedge clk_out);
      start_stop = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk_out);
      clear = 1'b0;
      @(negedge clk_out);
   endtask

   task automatic preload(input int t);
      total = t;
      drive_digits();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt;
      repeat (3) @(negedge clk_out);
      reset = 1'b0;
      chk("reset_state", state, 3'b000);
      chk("reset_inc", increase, 1'b0);
      chk("reset_dec", decrease, 1'b0);
      chk("reset_done", done, 1'b0);

      // Count up from 00:00: first strobe 4 edges after start, then every 4.
      up_dn = 1'b1;
      pulse_ss();
      chk("start_state", state, 3'b001);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_out); n++;
         if (increase) break;
      end
      chk("first_gap", n, 4);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_out); n++;
         if (increase) break;
      end
      chk("period", n, 4);
      chk("up_no_dec", decrease, 1'b0);

      // Count down from 00:02: exactly two decrease pulses then DONE.
      do_clear();
      preload(2);
      up_dn = 1'b0;
      pulse_ss();
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_out);
         if (decrease) cnt++;
         if (state == S_DONE) break;
      end
      repeat (10) begin
         @(negedge clk_out);
         if (decrease) cnt++;
      end
      chk("down_pulses", cnt, 2);
      chk("down_state", state, 3'b011);
      chk("down_done", done, 1'b1);
      chk("down_total", total, 0);

      // Count up from 59:58: one increase, DONE, start_stop ignored.
      do_clear();
      preload(3598);
      up_dn = 1'b1;
      pulse_ss();
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_out);
         if (increase) cnt++;
         if (state == S_DONE) break;
      end
      chk("up_pulses", cnt, 1);
      chk("up_state", state, 3'b011);
      pulse_ss();
      @(negedge clk_out);
      chk("done_ignores_ss", state, 3'b011);
      chk("done_flag", done, 1'b1);

      // Pause after two RUN cycles, hold 10, resume: strobe 2 cycles later.
      do_clear();
      up_dn = 1'b1;
      pulse_ss();
      repeat (2) @(negedge clk_out);
      pulse_ss();
      chk("pause_state", state, 3'b010);
      cnt = 0;
      repeat (10) begin
         @(negedge clk_out);
         if (increase || decrease) cnt++;
      end
      chk("pause_no_strobe", cnt, 0);
      pulse_ss();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_out); n++;
         if (increase) break;
      end
      chk("resume_gap", n, 2);

      // clear and start_stop together in RUN: CLEAR for one cycle, then IDLE.
      clear = 1'b1;
      start_stop = 1'b1;
      @(negedge clk_out);
      clear = 1'b0;
      start_stop = 1'b0;
      chk("clr_state", state, 3'b100);
      chk("clr_inc", increase, 1'b0);
      chk("clr_dec", decrease, 1'b0);
      @(negedge clk_out);
      chk("clr_idle", state, 3'b000);
      up_dn = 1'b0;
      pulse_ss();
      chk("term_start_idle", state, 3'b000);
      @(negedge clk_out);
      chk("term_start_idle2", state, 3'b000);

      // Asynchronous reset while increase is high.
      up_dn = 1'b1;
      pulse_ss();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_out);
         if (increase) break;
      end
      chk("rst_wait_inc", increase, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rst_async_inc", increase, 1'b0);
      chk("rst_async_state", state, 3'b000);
      chk("rst_async_done", done, 1'b0);
      model_reset();
      @(negedge clk_out);
      reset = 1'b0;
      cnt = 0;
      repeat (12) begin
         @(negedge clk_out);
         if (increase || decrease || state != S_IDLE) cnt++;
      end
      chk("rst_quiet", cnt, 0);

      // Randomized pulses, directions and preloads against the model.
      for (int i = 0; i < 3000; i++) begin
         start_stop = ($urandom_range(0, 11) == 0);
         clear      = ($urandom_range(0, 79) == 0);
         up_dn      = 1'($urandom_range(0, 1));
         if (m_state == S_IDLE && !start_stop && !clear && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 6))
               0: preload(0);
               1: preload(1);
               2: preload(2);
               3: preload(3597);
               4: preload(3598);
               5: preload(3599);
               default: preload(int'($urandom_range(0, 3599)));
            endcase
         end
         @(negedge clk_out);
      end
      start_stop = 1'b0;
      clear = 1'b0;
      @(negedge clk_out);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Run controller for the four-digit MM:SS timer. It paces the digit chain by issuing one-cycle `increase`/`decrease` strobes to the seconds-units digit counter at a fixed tick rate, and broadcasts the 3-bit `state` bus that all digit counters decode. It watches the four digit values to stop at the terminal count. It sits between the debounced push-button pulses and the digit-counter chain, which handles carry and borrow between digits by itself.

## Interface
- `TICK_DIV`, 100: `clk_out` cycles per count step; legal range 2..127.
- `TICK_W`, 7: width of the tick counter; must satisfy 2^TICK_W ≥ TICK_DIV.

- `clk_out`  in  1  system clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_stop`  in  1  one-cycle debounced pulse: start, pause or resume.
- `clear`  in  1  one-cycle debounced pulse: zero the digits.
- `up_dn`  in  1  count direction, 1 = up, 0 = down; sampled only on the start edge in IDLE.
- `sec0`, `sec1`, `min0`, `min1`  in  4 each  current BCD digit values from the digit counters.
- `increase`  out  1  one-cycle count-up strobe to the seconds-units digit.
- `decrease`  out  1  one-cycle count-down strobe to the seconds-units digit.
- `state`  out  3  controller state, decoded by the digit counters.
- `done`  out  1  high while in DONE.

## Operation
- States and encodings:
  - IDLE = 3'b000
  - RUN = 3'b001
  - PAUSE = 3'b010
  - DONE = 3'b011
  - CLEAR = 3'b100
- `state` is the registered state. CLEAR instructs the digit counters to load 0.
- Internal registers: `dir` (latched count direction) and `tick_cnt` (TICK_W bits).
- Terminal condition, evaluated combinationally from the digit inputs:
  - `dir`=1 (up): min1=5, min0=9, sec1=5, sec0=9.
  - `dir`=0 (down): all four digits 0.
- Transition priority each edge: `clear` first, then terminal check, then `start_stop`.
- Any state, `clear`=1 → CLEAR; `tick_cnt`←0; strobes←0.
- CLEAR → IDLE unconditionally on the next edge.
- IDLE with `start_stop`:
  - Terminal condition for `up_dn` true: stay IDLE.
  - Otherwise: `dir`←`up_dn`, `tick_cnt`←0, → RUN.
- RUN with terminal condition true: → DONE; strobes←0; no further strobes are issued.
- RUN with `start_stop`: → PAUSE; `tick_cnt` holds; strobes←0.
- RUN otherwise:
  - `tick_cnt`=TICK_DIV-1: `tick_cnt`←0, and `increase`←`dir` or `decrease`←~`dir`.
  - Else: `tick_cnt`←`tick_cnt`+1, strobes←0.
- PAUSE with `start_stop`: → RUN, resuming from the held `tick_cnt`.
- PAUSE otherwise: everything holds.
- DONE: `start_stop` ignored; only `clear` leaves.
- `increase` and `decrease` are never high together. Both are 0 outside RUN.
- `done` is registered and equals (next state == DONE).

## Timing
- Reset values: `state`=IDLE, `increase`=0, `decrease`=0, `done`=0, `tick_cnt`=0, `dir`=1.
- Reset does not zero the digit counters; a `clear` pulse is required for that.
- Start latency: `start_stop` is sampled at edge E0 and `state`=RUN after E0. The first strobe is high for the cycle after edge E0+TICK_DIV.
- Strobe period in continuous RUN is exactly TICK_DIV cycles. Each strobe lasts exactly 1 cycle.
- Digit values reflect a strobe one edge after it. TICK_DIV ≥ 2 guarantees the terminal check sees the updated value before the next strobe can fire.
- Terminal detect: DONE and `done`=1 on the first edge at which the final digit value is visible on the inputs.
- Pause/resume is tick-exact: the total RUN cycles between strobes remain TICK_DIV.
- `clear` and `start_stop` on the same edge: clear wins and `start_stop` is discarded.
- Reset asserted mid-RUN: all outputs drop asynchronously, with no partial strobe. After release the controller waits in IDLE.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then start with `up_dn`=1 from 00:00:
  - `state`=001 one cycle after the start edge.
  - `increase` pulses 1 cycle wide, first after 4 edges, then every 4 cycles.
  - `decrease` stays 0.
- Count down from digits 00:02 with `up_dn`=0: exactly 2 `decrease` pulses, then `state`=011 and `done`=1. No third pulse occurs.
- Count up from 59:58: exactly 1 `increase` pulse, then DONE when the inputs read 59:59. `start_stop` in DONE leaves `state`=011.
- `start_stop` after 2 RUN cycles, hold PAUSE 10 cycles, then `start_stop` again: the next strobe comes 2 RUN cycles after resume. No strobe occurs during PAUSE.
- `clear` and `start_stop` together in RUN:
  - `state`=100 for exactly 1 cycle, then 000.
  - Strobes are 0 throughout.
  - Starting with digits already at the terminal value (00:00, `up_dn`=0) keeps `state`=000.
- Assert `reset` asynchronously mid-cycle while `increase` is high: `increase`, `done` and `state` go to 0 immediately. After release no strobe appears until a new `start_stop`.
